// File: rtl/norm_sqrt_if.sv
// Handshake/result bundle between the norm processor and norm_sqrt.
// master = upstream requester, slave = the square-root block.
interface norm_sqrt_if;
  logic        start;
  logic [38:0] norm2_in;
  logic        busy;
  logic        done;
  logic [23:0] norm_out;
  logic        ovf;

  modport master (output start, norm2_in, input busy, done, norm_out, ovf);
  modport slave  (input start, norm2_in, output busy, done, norm_out, ovf);
endinterface

// File: rtl/norm_sqrt.sv
// Converts a squared norm (M x 2^E) into its root in memory word format.
// Optional rounding of the halved root is enabled by defining NORM_SQRT_ROUND_EN.
module norm_sqrt (
  input  logic         clk,
  input  logic         rst_n,
  norm_sqrt_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIN} state_t;

  state_t      state, state_next;
  logic [38:0] op_q;        // captured operand: [38:30] E, [29:0] M
  logic [31:0] x_q;         // radicand, consumed two bits per iteration
  logic [17:0] rem_q;
  logic [15:0] root_q;
  logic [3:0]  cnt_q;
  logic [7:0]  exp_half_q;  // E'/2, identical to E>>1 for odd or even E

  // One restoring root step: bring down two bits, try to subtract 4r+1.
  logic [17:0] rem_shift, trial, rem_next;
  logic [15:0] root_next;

  always_comb begin
    rem_shift = (rem_q << 2) | {16'd0, x_q[31:30]};
    trial     = {root_q, 2'b01};
    rem_next  = rem_shift;
    root_next = {root_q[14:0], 1'b0};
    if (rem_shift >= trial) begin
      rem_next  = rem_shift - trial;
      root_next = {root_q[14:0], 1'b1};
    end
  end

  // Result formatting from the finished root.
  logic [9:0]  e_calc;
  logic [14:0] m_calc;
  logic        sat;
`ifdef NORM_SQRT_ROUND_EN
  logic [15:0] sum16;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    e_calc = '0;
    m_calc = '0;
`ifdef NORM_SQRT_ROUND_EN
    sum16  = {1'b0, root_q[15:1]} + {15'd0, root_q[0]};
`endif
    if (root_q == 16'd0) begin
      // Zero mantissa: exponent is forced to zero whatever E was.
      e_calc = '0;
      m_calc = '0;
    end else if (!root_q[15]) begin
      e_calc = {2'b00, exp_half_q};
      m_calc = root_q[14:0];
    end else begin
`ifdef NORM_SQRT_ROUND_EN
      if (sum16[15]) begin
        e_calc = {2'b00, exp_half_q} + 10'd2;
        m_calc = 15'h4000;
      end else begin
        e_calc = {2'b00, exp_half_q} + 10'd1;
        m_calc = sum16[14:0];
      end
`else
      e_calc = {2'b00, exp_half_q} + 10'd1;
      m_calc = root_q[15:1];
`endif
    end
    sat = (e_calc > 10'd255);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.start) state_next = PREP;
      PREP: state_next = ITER;
      ITER: if (cnt_q == 4'd15) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      x_q          <= '0;
      rem_q        <= '0;
      root_q       <= '0;
      cnt_q        <= '0;
      exp_half_q   <= '0;
      bus.done     <= 1'b0;
      bus.norm_out <= '0;
      bus.ovf      <= 1'b0;
    end else begin
      bus.done <= (state == FIN);
      unique case (state)
        IDLE: if (bus.start) op_q <= bus.norm2_in;
        PREP: begin
          // Odd exponent: double the mantissa so the exponent becomes even.
          x_q        <= op_q[30] ? {1'b0, op_q[29:0], 1'b0} : {2'b00, op_q[29:0]};
          exp_half_q <= op_q[38:31];
          rem_q      <= '0;
          root_q     <= '0;
          cnt_q      <= '0;
        end
        ITER: begin
          x_q    <= x_q << 2;
          rem_q  <= rem_next;
          root_q <= root_next;
          cnt_q  <= cnt_q + 4'd1;
        end
        FIN: begin
          bus.norm_out <= sat ? {1'b0, 8'hFF, 15'h7FFF} : {1'b0, e_calc[7:0], m_calc};
          bus.ovf      <= sat;
        end
        default: ;
      endcase
    end
  end

endmodule
